// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial datapath blocks.
//   - State encodings for the serial subtractor controller.
//   - clog2 helper used to size step counters.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin.
// Ports:
//   x     in   minuend bit
//   y     in   subtrahend bit
//   bin   in   borrow in from the less significant cell
//   d     out  difference bit
//   bout  out  borrow out to the more significant cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle subtractor: diff = a - b, DIGIT bits resolved per clock with
// the borrow carried between cycles in a register.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   in_valid   in   operands a/b valid
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   minuend
//   b          in   subtrahend
//   out_valid  out  diff/bout/ovf valid (DONE only)
//   out_ready  in   consumer accepts result
//   diff       out  a - b mod 2^WIDTH
//   bout       out  unsigned underflow (a < b)
//   ovf        out  signed overflow of a - b
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | rippling DIGIT bits per cycle, NSTEP cycles
// DONE  | result held on outputs until out_ready
module serial_ripple_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(NSTEP) > 0) ? clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

  state_t state;
  state_t state_nxt;

  logic accept;
  logic step;
  logic last_step;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] chain_ext;
  logic [CNT_W-1:0] cnt;
  logic             borrow_q;
  logic             a_msb;
  logic             b_msb;

  logic [DIGIT:0]   chain_b;
  logic [DIGIT-1:0] chain_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Borrow chain across the low DIGIT bits of the operand shift registers.
  assign chain_b[0] = borrow_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    full_subtractor u_fs (
      .x    (a_sr[i]),
      .y    (b_sr[i]),
      .bin  (chain_b[i]),
      .d    (chain_d[i]),
      .bout (chain_b[i+1])
    );
  end

  // New digit enters at the top so that after NSTEP steps the first digit
  // computed has reached bit 0.
  assign chain_ext = WIDTH'(chain_d);
  assign res_next  = (res_sr >> DIGIT) | (chain_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      borrow_q <= 1'b0;
      cnt      <= '0;
      a_msb    <= a[WIDTH-1];
      b_msb    <= b[WIDTH-1];
    end else if (step) begin
      a_sr     <= a_sr >> DIGIT;
      b_sr     <= b_sr >> DIGIT;
      res_sr   <= res_next;
      borrow_q <= chain_b[DIGIT];
      cnt      <= cnt + CNT_W'(1);
      // Output registers load only on the final step, so they hold their
      // value through DONE and after the handshake.
      if (last_step) begin
        diff <= res_next;
        bout <= chain_b[DIGIT];
        ovf  <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
      end
    end
  end

endmodule
